// File: rtl/irq_controller.sv
// Prioritising interrupt controller: edge/level request latching, masking,
// nested fixed-priority selection against in-service sources, 4-word bridge window.
module irq_controller #(
  parameter int               N_SRC    = 6,
  parameter logic [N_SRC-1:0] MODE_RST = N_SRC'(6'b000011)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             We,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      WD,
  output logic [31:0]      RD,
  output logic [N_SRC-1:0] irq_out,
  output logic             cpu_irq,
  output logic [2:0]       irq_id
);

  logic [1:0]       addr;
  logic             wr_ctrl, wr_mode, wr_pend, wr_isr, claim, eoi;
  logic [N_SRC-1:0] mask, mode, pend, prev, in_service;
  logic             gen;
  logic [N_SRC-1:0] pend_nxt, isr_nxt;
  logic             id_hit, clr;
  logic [N_SRC-1:0] cand_p0;
  logic             sel_vld_p0, blocked;
  logic [2:0]       sel_idx_p0;
  logic [7:0]       isr8;
  logic             unused_bits;

  assign addr        = ADDR[3:2];
  assign unused_bits = ^{ADDR[31:4], ADDR[1:0], WD};
  assign wr_ctrl     = We && (addr == 2'd0);
  assign wr_mode     = We && (addr == 2'd1);
  assign wr_pend     = We && (addr == 2'd2);
  assign wr_isr      = We && (addr == 2'd3);
  assign claim       = wr_isr && !WD[8];
  assign eoi         = wr_isr &&  WD[8];

  // Next pending / in-service; a fresh edge overrides any same-cycle clear.
  // Ids >= N_SRC never match a loop index, so such commands are dropped.
  always_comb begin
    pend_nxt = pend;
    isr_nxt  = in_service;
    id_hit   = 1'b0;
    clr      = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      id_hit = (WD[2:0] == 3'(i));
      clr    = (wr_pend && WD[i]) || (claim && id_hit);
      if (mode[i])
        pend_nxt[i] = (irq_in[i] && !prev[i]) || (pend[i] && !clr);
      else
        pend_nxt[i] = irq_in[i];
      if (claim && id_hit)
        isr_nxt[i] = 1'b1;
      else if (eoi && id_hit)
        isr_nxt[i] = 1'b0;
    end
  end

  // Stage p0: scanning upward, the first in-service source blocks everything at or below it.
  always_comb begin
    cand_p0    = pend & mask & {N_SRC{gen}};
    sel_vld_p0 = 1'b0;
    sel_idx_p0 = 3'd0;
    blocked    = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!sel_vld_p0 && !blocked) begin
        if (in_service[i]) begin
          blocked = 1'b1;
        end else if (cand_p0[i]) begin
          sel_vld_p0 = 1'b1;
          sel_idx_p0 = 3'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask       <= '0;
      gen        <= 1'b0;
      mode       <= MODE_RST;
      pend       <= '0;
      prev       <= '0;
      in_service <= '0;
      irq_out    <= '0;
      cpu_irq    <= 1'b0;
      irq_id     <= 3'd0;
    end else begin
      if (wr_ctrl) begin
        mask <= WD[N_SRC-1:0];
        gen  <= WD[31];
      end
      if (wr_mode)
        mode <= WD[N_SRC-1:0];
      pend       <= pend_nxt;
      prev       <= irq_in;
      in_service <= isr_nxt;
      // Stage p1: registered request to the CPU.
      irq_out    <= sel_vld_p0 ? (N_SRC'(1) << sel_idx_p0) : '0;
      cpu_irq    <= sel_vld_p0;
      irq_id     <= sel_idx_p0;
    end
  end

  always_comb begin
    RD   = '0;
    isr8 = '0;
    isr8[N_SRC-1:0] = in_service;
    case (addr)
      2'd0: begin
        RD[N_SRC-1:0] = mask;
        RD[31]        = gen;
      end
      2'd1:    RD[N_SRC-1:0] = mode;
      2'd2:    RD[N_SRC-1:0] = pend;
      default: RD = {cpu_irq, 20'b0, irq_id, isr8};
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: vector table, directed nesting/reset sequences,
// and randomized traffic against a rule-level reference model.
module tb_irq_controller;
  localparam int N = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic          We = 1'b0;
  logic [31:0]   ADDR = '0;
  logic [31:0]   WD = '0;
  logic [31:0]   RD;
  logic [N-1:0]  irq_out;
  logic          cpu_irq;
  logic [2:0]    irq_id;

  irq_controller #(.N_SRC(N), .MODE_RST(6'b000011)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .We(We), .ADDR(ADDR), .WD(WD),
    .RD(RD), .irq_out(irq_out), .cpu_irq(cpu_irq), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference state
  bit [N-1:0] m_mask, m_mode, m_pend, m_prev, m_isr, m_out;
  bit         m_gen, m_cpu;
  bit [2:0]   m_id;

  typedef struct {
    bit         we;
    bit [1:0]   a;
    bit [31:0]  wd;
    bit [N-1:0] irq;
    bit [N-1:0] e_out;
    bit [2:0]   e_id;
    bit         e_cpu;
    bit [31:0]  e_rd;
  } vec_t;
  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mask = '0; m_gen = 1'b0; m_mode = 6'b000011; m_pend = '0; m_prev = '0;
    m_isr = '0; m_out = '0; m_cpu = 1'b0; m_id = 3'd0;
  endtask

  function automatic logic [31:0] model_rd(input bit [1:0] a);
    case (a)
      2'd0:    return {m_gen, 25'b0, m_mask};
      2'd1:    return {26'b0, m_mode};
      2'd2:    return {26'b0, m_pend};
      default: return {m_cpu, 20'b0, m_id, 2'b0, m_isr};
    endcase
  endfunction

  // One clock edge of the spec rules: outputs from pre-edge state, then state update.
  task automatic model_step(input bit we, input bit [1:0] a, input bit [31:0] wd, input bit [N-1:0] irq);
    bit [N-1:0] cand, np;
    int lim, win, id;
    bit hit_clr;
    cand = m_pend & m_mask & {N{m_gen}};
    lim = N;
    for (int i = N - 1; i >= 0; i--) if (m_isr[i]) lim = i;
    win = -1;
    for (int i = N - 1; i >= 0; i--) if (cand[i]) win = i;
    if (win >= 0 && win < lim) begin
      m_out = N'(1) << win; m_id = 3'(win); m_cpu = 1'b1;
    end else begin
      m_out = '0; m_id = 3'd0; m_cpu = 1'b0;
    end
    id = int'(wd[2:0]);
    for (int i = 0; i < N; i++) begin
      if (!m_mode[i]) np[i] = irq[i];
      else begin
        hit_clr = (we && a == 2'd2 && wd[i]) || (we && a == 2'd3 && !wd[8] && id == i);
        if (irq[i] && !m_prev[i]) np[i] = 1'b1;
        else if (hit_clr)         np[i] = 1'b0;
        else                      np[i] = m_pend[i];
      end
    end
    m_pend = np;
    m_prev = irq;
    if (we && a == 2'd3 && id < N) m_isr[id] = !wd[8];
    if (we && a == 2'd0) begin m_mask = wd[N-1:0]; m_gen = wd[31]; end
    if (we && a == 2'd1) m_mode = wd[N-1:0];
  endtask

  task automatic step(input bit we, input bit [1:0] a, input bit [31:0] wd, input bit [N-1:0] irq);
    We = we; ADDR = {28'b0, a, 2'b00}; WD = wd; irq_in = irq;
    @(posedge clk);
    model_step(we, a, wd, irq);
    #1;
    check("model irq_out", 32'(irq_out), 32'(m_out));
    check("model cpu_irq", 32'(cpu_irq), 32'(m_cpu));
    check("model irq_id",  32'(irq_id),  32'(m_id));
    check("model RD",      RD,           model_rd(a));
  endtask

  task automatic do_reset();
    We = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check("reset irq_out", 32'(irq_out), 32'h0);
    check("reset cpu_irq", 32'(cpu_irq), 32'h0);
    check("reset irq_id",  32'(irq_id),  32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit [N-1:0] r_irq;
    bit [31:0]  r_wd;
    bit [1:0]   r_a;

    tbl[0]  = '{1'b1, 2'd0, 32'h8000_003F, 6'b000000, 6'b000000, 3'd0, 1'b0, 32'h8000_003F};
    tbl[1]  = '{1'b1, 2'd1, 32'h0000_0003, 6'b000000, 6'b000000, 3'd0, 1'b0, 32'h0000_0003};
    tbl[2]  = '{1'b0, 2'd2, 32'h0,         6'b000001, 6'b000000, 3'd0, 1'b0, 32'h0000_0001};
    tbl[3]  = '{1'b0, 2'd2, 32'h0,         6'b000000, 6'b000001, 3'd0, 1'b1, 32'h0000_0001};
    tbl[4]  = '{1'b0, 2'd3, 32'h0,         6'b000000, 6'b000001, 3'd0, 1'b1, 32'h8000_0000};
    tbl[5]  = '{1'b1, 2'd2, 32'h0000_0001, 6'b000000, 6'b000001, 3'd0, 1'b1, 32'h0000_0000};
    tbl[6]  = '{1'b0, 2'd3, 32'h0,         6'b000000, 6'b000000, 3'd0, 1'b0, 32'h0000_0000};
    tbl[7]  = '{1'b0, 2'd2, 32'h0,         6'b001000, 6'b000000, 3'd0, 1'b0, 32'h0000_0008};
    tbl[8]  = '{1'b0, 2'd3, 32'h0,         6'b001000, 6'b001000, 3'd3, 1'b1, 32'h8000_0300};
    tbl[9]  = '{1'b0, 2'd2, 32'h0,         6'b000000, 6'b001000, 3'd3, 1'b1, 32'h0000_0000};
    tbl[10] = '{1'b0, 2'd3, 32'h0,         6'b000000, 6'b000000, 3'd0, 1'b0, 32'h0000_0000};

    #3;
    do_reset();
    ADDR = 32'h4;
    #1 check("reset MODE", RD, 32'h3);
    ADDR = 32'h0;
    #1 check("reset CTRL", RD, 32'h0);

    // Edge source 0 latch/W1C, then level source 3 follow
    for (int k = 0; k < 11; k++) begin
      step(tbl[k].we, tbl[k].a, tbl[k].wd, tbl[k].irq);
      check($sformatf("vec%0d irq_out", k), 32'(irq_out), 32'(tbl[k].e_out));
      check($sformatf("vec%0d irq_id", k),  32'(irq_id),  32'(tbl[k].e_id));
      check($sformatf("vec%0d cpu_irq", k), 32'(cpu_irq), 32'(tbl[k].e_cpu));
      check($sformatf("vec%0d RD", k),      RD,           tbl[k].e_rd);
    end

    // Nesting: src 0 preempts in-service 3, src 4 waits for both EOIs
    step(1'b1, 2'd3, 32'h003, 6'b000000);
    step(1'b0, 2'd0, 32'h0,   6'b010001);
    step(1'b0, 2'd0, 32'h0,   6'b010000);
    check("preempt irq_out", 32'(irq_out), 32'h01);
    step(1'b1, 2'd3, 32'h000, 6'b010000);
    step(1'b0, 2'd0, 32'h0,   6'b010000);
    check("blocked cpu_irq", 32'(cpu_irq), 32'h0);
    step(1'b1, 2'd3, 32'h103, 6'b010000);
    step(1'b0, 2'd0, 32'h0,   6'b010000);
    check("after eoi3 cpu_irq", 32'(cpu_irq), 32'h0);
    step(1'b1, 2'd3, 32'h100, 6'b010000);
    step(1'b0, 2'd3, 32'h0,   6'b010000);
    check("after eoi0 irq_id", 32'(irq_id), 32'h4);
    check("after eoi0 irq_out", 32'(irq_out), 32'h10);
    step(1'b0, 2'd0, 32'h0, 6'b000000);
    step(1'b0, 2'd0, 32'h0, 6'b000000);

    // Edge set beats same-cycle W1C
    step(1'b1, 2'd2, 32'h2, 6'b000010);
    check("set wins PEND", RD, 32'h2);
    step(1'b0, 2'd2, 32'h0, 6'b000000);
    check("set wins irq_id", 32'(irq_id), 32'h1);
    step(1'b1, 2'd2, 32'h2, 6'b000000);
    step(1'b0, 2'd0, 32'h0, 6'b000000);
    check("cleared cpu_irq", 32'(cpu_irq), 32'h0);

    // Global enable gate with all sources pending in level mode
    step(1'b1, 2'd0, 32'h3F, 6'b111111);
    step(1'b1, 2'd1, 32'h00, 6'b111111);
    step(1'b0, 2'd0, 32'h0,  6'b111111);
    step(1'b0, 2'd0, 32'h0,  6'b111111);
    check("gen off irq_out", 32'(irq_out), 32'h0);
    check("gen off CTRL", RD, 32'h3F);
    step(1'b1, 2'd0, 32'h8000_003F, 6'b111111);
    check("gen edge1 irq_out", 32'(irq_out), 32'h0);
    step(1'b0, 2'd0, 32'h0, 6'b111111);
    check("gen edge2 irq_out", 32'(irq_out), 32'h01);
    check("gen edge2 irq_id", 32'(irq_id), 32'h0);

    // Reset mid-claim with in_service = 0x09 and cpu_irq high
    step(1'b1, 2'd3, 32'h003, 6'b111111);
    step(1'b1, 2'd3, 32'h000, 6'b111111);
    check("preclaim cpu_irq", 32'(cpu_irq), 32'h1);
    check("preclaim ISR", RD, 32'h8000_0009);
    do_reset();
    ADDR = 32'h4;
    #1 check("post reset MODE", RD, 32'h3);
    ADDR = 32'hC;
    #1 check("post reset ISR", RD, 32'h0);

    // Randomized traffic
    r_irq = '0;
    step(1'b1, 2'd0, 32'h8000_003F, r_irq);
    for (int k = 0; k < 600; k++) begin
      if (k % 200 == 199) begin
        do_reset();
        step(1'b1, 2'd0, 32'h8000_003F, r_irq);
      end
      if ($urandom_range(0, 2) == 0) r_irq = r_irq ^ 6'($urandom);
      r_a  = 2'($urandom_range(0, 3));
      r_wd = $urandom;
      if (r_a == 2'd3) r_wd = {23'b0, r_wd[8], 5'b0, r_wd[2:0]};
      if (r_a == 2'd0 && $urandom_range(0, 3) != 0) r_wd[31] = 1'b1;
      step($urandom_range(0, 3) == 0, r_a, r_wd, r_irq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
